keypad_ctrl: RTL

Scan sequencer, debouncer and CPU-facing request controller for the 4x4 CHIP-8 hex keypad matrix. Drives the one-hot column lines with a configurable settle time, samples rows, maintains a debounced 16-bit key state, and serves the CPU's key instructions through a request/response handshake. EX9E/EXA1 use the query op; FX0A uses the wait op, which blocks until a key is pressed and released. Sits between the keypad pins and the CPU execute stage.

---
 rtl/keypad_pkg.sv | 33 +++
 rtl/keypad_debounce.sv | 56 +++++
 rtl/keypad_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants, request opcodes and request FSM states for
// the 4x4 hex keypad controller.
package keypad_pkg;

  localparam int unsigned KEY_COUNT = 16;
  localparam int unsigned COL_COUNT = 4;

  localparam logic [1:0] OP_QUERY = 2'b00;
  localparam logic [1:0] OP_WAIT  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_PRESS,
    ST_WAIT_RELEASE,
    ST_RESP
  } req_state_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [3:0] lowest_set(input logic [KEY_COUNT-1:0] v);
    logic [3:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < KEY_COUNT; i++) begin
      if (v[i] && !found) begin
        idx   = i[3:0];
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: per-key debouncer. Built only when KEYPAD_DEBOUNCE_EN is
// defined. The stable bit flips after DEBOUNCE_SCANS consecutive scans whose
// raw sample disagrees with it; any agreeing scan clears the count.
// o_stable_next is the value o_stable takes at the coming clock edge, used by
// the controller for same-scan edge/release detection.
`ifdef KEYPAD_DEBOUNCE_EN
module keypad_debounce #(
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  input  logic i_scan_done,
  output logic o_stable,
  output logic o_stable_next
);

  localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_stable;
  logic          w_stable_next;

  // Next count / stable value, evaluated once per full scan.
  always_comb begin
    w_cnt_next    = r_cnt;
    w_stable_next = r_stable;
    if (i_scan_done) begin
      if (i_raw == r_stable) begin
        w_cnt_next = '0;
      end else if (r_cnt == CW'(DEBOUNCE_SCANS - 1)) begin
        w_cnt_next    = '0;
        w_stable_next = ~r_stable;
      end else begin
        w_cnt_next = r_cnt + 1'b1;
      end
    end
  end

  // Counter and stable-state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_next;
      r_stable <= w_stable_next;
    end
  end

  assign o_stable      = r_stable;
  assign o_stable_next = w_stable_next;

endmodule
`endif

// File: rtl/keypad_ctrl.sv
// keypad_ctrl: 4x4 keypad column scanner, key-state tracker and CPU
// request/response controller (query and wait-for-key-press-and-release).
// Optional feature macro: KEYPAD_DEBOUNCE_EN (per-key debounce via
// keypad_debounce); when undefined, keys follow the raw scan directly.
module keypad_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [3:0]  column,
  input  logic [3:0]  row,
  output logic [15:0] keys,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [3:0]  req_key,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_hit,
  output logic [3:0]  rsp_key,
  input  logic        cancel
);

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  if (SETTLE_CYCLES < 1 || DEBOUNCE_SCANS < 1) begin : g_bad_cfg
    $error("keypad_ctrl: SETTLE_CYCLES and DEBOUNCE_SCANS must be >= 1");
  end

  // ---------------------------------------------------------------- scan
  logic [SW-1:0]          r_settle_cnt;
  logic [1:0]             r_col_idx;
  logic [KEY_COUNT-1:0]   r_raw;
  logic [KEY_COUNT-1:0]   w_raw_next;
  logic                   w_sample;
  logic                   w_scan_done;

  assign w_sample    = (r_settle_cnt == SW'(SETTLE_CYCLES - 1));
  assign w_scan_done = w_sample && (r_col_idx == 2'd3);
  assign column      = 4'b0001 << r_col_idx;

  // Settle counter and column index; column advances after its sample cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle_cnt <= '0;
      r_col_idx    <= '0;
    end else if (w_sample) begin
      r_settle_cnt <= '0;
      r_col_idx    <= r_col_idx + 2'd1;
    end else begin
      r_settle_cnt <= r_settle_cnt + 1'b1;
    end
  end

  // Raw image with the current column's rows merged in on its sample cycle,
  // so the column-3 sample is visible to the key logic on scan_done itself.
  always_comb begin
    logic [3:0] w_idx;
    w_raw_next = r_raw;
    w_idx      = '0;
    if (w_sample) begin
      for (int unsigned i = 0; i < COL_COUNT; i++) begin
        w_idx             = {i[1:0], r_col_idx};
        w_raw_next[w_idx] = row[i];
      end
    end
  end

  // Raw sample register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raw <= '0;
    end else begin
      r_raw <= w_raw_next;
    end
  end

  // ---------------------------------------------------------------- keys
  logic [KEY_COUNT-1:0] w_keys;
  logic [KEY_COUNT-1:0] w_keys_next;
  logic [KEY_COUNT-1:0] w_newly;

`ifdef KEYPAD_DEBOUNCE_EN
  for (genvar k = 0; k < KEY_COUNT; k++) begin : g_deb
    keypad_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_deb (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_raw        (w_raw_next[k]),
      .i_scan_done  (w_scan_done),
      .o_stable     (w_keys[k]),
      .o_stable_next(w_keys_next[k])
    );
  end
`else
  logic [KEY_COUNT-1:0] r_keys;

  assign w_keys_next = w_scan_done ? w_raw_next : r_keys;

  // Keys follow the raw image once per completed scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_keys <= '0;
    end else begin
      r_keys <= w_keys_next;
    end
  end

  assign w_keys = r_keys;
`endif

  assign keys    = w_keys;
  assign w_newly = w_scan_done ? (w_keys_next & ~w_keys) : '0;

  // ------------------------------------------------------- request FSM
  req_state_t   r_state;
  req_state_t   w_state_next;
  logic         r_rsp_hit;
  logic         w_rsp_hit_next;
  logic [3:0]   r_rsp_key;
  logic [3:0]   w_rsp_key_next;

  // Request state and response data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_rsp_hit <= 1'b0;
      r_rsp_key <= '0;
    end else begin
      r_state   <= w_state_next;
      r_rsp_hit <= w_rsp_hit_next;
      r_rsp_key <= w_rsp_key_next;
    end
  end

  // Next state, response data loads and handshake outputs.
  always_comb begin
    logic w_do_query;
    w_state_next   = r_state;
    w_rsp_hit_next = r_rsp_hit;
    w_rsp_key_next = r_rsp_key;
    w_do_query     = 1'b0;
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          case (req_op)
            OP_WAIT:  w_state_next = ST_WAIT_PRESS;
            OP_QUERY: w_do_query   = 1'b1;
            default:  w_do_query   = 1'b1;
          endcase
          if (w_do_query) begin
            w_rsp_hit_next = w_keys[req_key];
            w_state_next   = ST_RESP;
          end
        end
      end
      ST_WAIT_PRESS: begin
        if (cancel) begin
          w_state_next = ST_IDLE;
        end else if (|w_newly) begin
          w_rsp_key_next = lowest_set(w_newly);
          w_state_next   = ST_WAIT_RELEASE;
        end
      end
      ST_WAIT_RELEASE: begin
        if (cancel) begin
          w_state_next = ST_IDLE;
        end else if (w_scan_done && !w_keys_next[r_rsp_key]) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign rsp_hit = r_rsp_hit;
  assign rsp_key = r_rsp_key;

endmodule
